// File: rtl/lif_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lif_core_scheduler
// Purpose  : Time-multiplexes one 8-bit leaky-integrate-fire update datapath
//            across N_NEURONS neurons. Each accepted tick snapshots the input
//            currents and the pending threshold, then sweeps neurons 0..N-1,
//            one per clock, reporting spikes as they happen and as a vector
//            once the sweep completes.
// Ports    : clk, rst_n (sync, active-low)
//            i_tick                      start one sweep (ignored while busy)
//            i_cur_wr_en/addr/data       pending input-current write
//            i_thr_wr_en/data            pending global-threshold write
//            i_rd_addr -> o_rd_state     combinational membrane-state read
//            o_busy, o_done              sweep in progress / sweep finished
//            o_spike_valid, o_spike_id   per-neuron fire pulse
//            o_spike_vec                 fire mask of the last finished sweep
//            o_overrun                   tick dropped because a sweep was running
// Revision : 1.0  initial release
// ============================================================================
module lif_core_scheduler #(
  parameter int          N_NEURONS  = 4,
  parameter logic [7:0]  THRESH_RST = 8'd230,
  localparam int         ID_W       = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_tick,
  input  logic                 i_cur_wr_en,
  input  logic [ID_W-1:0]      i_cur_wr_addr,
  input  logic [7:0]           i_cur_wr_data,
  input  logic                 i_thr_wr_en,
  input  logic [7:0]           i_thr_wr_data,
  input  logic [ID_W-1:0]      i_rd_addr,
  output logic [7:0]           o_rd_state,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_spike_valid,
  output logic [ID_W-1:0]      o_spike_id,
  output logic [N_NEURONS-1:0] o_spike_vec,
  output logic                 o_overrun
);

  localparam logic [ID_W-1:0] c_LAST_IDX = ID_W'(N_NEURONS - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t r_fsm;
  state_t w_fsm_next;

  logic [7:0]           r_state    [N_NEURONS];
  logic [7:0]           r_cur_pend [N_NEURONS];
  logic [7:0]           r_cur_act  [N_NEURONS];
  logic [7:0]           r_thr_pend;
  logic [7:0]           r_thr_act;
  logic [ID_W-1:0]      r_idx;
  logic [N_NEURONS-1:0] r_acc;
  logic                 r_done;
  logic                 r_spike_valid;
  logic [ID_W-1:0]      r_spike_id;
  logic [N_NEURONS-1:0] r_spike_vec;
  logic                 r_overrun;

  logic                 w_accept;
  logic                 w_drop;
  logic                 w_update;
  logic                 w_last;
  logic [7:0]           w_s;
  logic                 w_fire;
  logic [7:0]           w_sum;
  logic [N_NEURONS-1:0] w_fire_vec;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_next;
  end

  // Next state and sweep control
  always_comb begin
    w_fsm_next = r_fsm;
    w_accept   = 1'b0;
    w_drop     = 1'b0;
    w_update   = 1'b0;
    w_last     = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (i_tick) begin
          w_accept   = 1'b1;
          w_fsm_next = S_SWEEP;
        end
      end
      S_SWEEP: begin
        w_update = 1'b1;
        w_drop   = i_tick;
        if (r_idx == c_LAST_IDX) begin
          w_last     = 1'b1;
          w_fsm_next = S_IDLE;
        end
      end
      default: w_fsm_next = S_IDLE;
    endcase
  end

  // Shared LIF datapath: leak is s*(1/2+1/4+1/8), all sums wrap mod 256
  always_comb begin
    w_s        = r_state[r_idx];
    w_fire     = (w_s >= r_thr_act);
    w_sum      = r_cur_act[r_idx] + (w_s >> 1) + (w_s >> 2) + (w_s >> 3);
    w_fire_vec = r_acc;
    w_fire_vec[r_idx] = w_fire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        r_state[i]    <= 8'd0;
        r_cur_pend[i] <= 8'd0;
        r_cur_act[i]  <= 8'd0;
      end
      r_thr_pend    <= THRESH_RST;
      r_thr_act     <= THRESH_RST;
      r_idx         <= '0;
      r_acc         <= '0;
      r_done        <= 1'b0;
      r_spike_valid <= 1'b0;
      r_spike_id    <= '0;
      r_spike_vec   <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_spike_valid <= 1'b0;
      r_overrun     <= w_drop;

      // Pending copies are written unconditionally; the snapshot below reads
      // their pre-edge values, so a same-cycle write lands in the next sweep.
      if (i_cur_wr_en && (int'(i_cur_wr_addr) < N_NEURONS))
        r_cur_pend[i_cur_wr_addr] <= i_cur_wr_data;
      if (i_thr_wr_en)
        r_thr_pend <= i_thr_wr_data;

      if (w_accept) begin
        r_cur_act <= r_cur_pend;
        r_thr_act <= r_thr_pend;
        r_idx     <= '0;
        r_acc     <= '0;
      end

      if (w_update) begin
        r_state[r_idx] <= w_fire ? 8'd0 : w_sum;
        r_spike_valid  <= w_fire;
        r_spike_id     <= r_idx;
        r_acc          <= w_fire_vec;
        r_idx          <= w_last ? '0 : r_idx + ID_W'(1);
        if (w_last) begin
          r_done      <= 1'b1;
          r_spike_vec <= w_fire_vec;
        end
      end
    end
  end

  assign o_rd_state    = (int'(i_rd_addr) < N_NEURONS) ? r_state[i_rd_addr] : 8'd0;
  assign o_busy        = (r_fsm == S_SWEEP);
  assign o_done        = r_done;
  assign o_spike_valid = r_spike_valid;
  assign o_spike_id    = r_spike_id;
  assign o_spike_vec   = r_spike_vec;
  assign o_overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_lif_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_core_scheduler
// Purpose  : Directed self-checking bench for lif_core_scheduler (N=4,
//            reset threshold 230). Expected values are hand-computed.
// Revision : 1.0  initial release
// ============================================================================
module tb_lif_core_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_tick;
  logic       i_cur_wr_en;
  logic [1:0] i_cur_wr_addr;
  logic [7:0] i_cur_wr_data;
  logic       i_thr_wr_en;
  logic [7:0] i_thr_wr_data;
  logic [1:0] i_rd_addr;
  logic [7:0] o_rd_state;
  logic       o_busy;
  logic       o_done;
  logic       o_spike_valid;
  logic [1:0] o_spike_id;
  logic [3:0] o_spike_vec;
  logic       o_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  lif_core_scheduler #(.N_NEURONS(4), .THRESH_RST(8'd230)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_tick        (i_tick),
    .i_cur_wr_en   (i_cur_wr_en),
    .i_cur_wr_addr (i_cur_wr_addr),
    .i_cur_wr_data (i_cur_wr_data),
    .i_thr_wr_en   (i_thr_wr_en),
    .i_thr_wr_data (i_thr_wr_data),
    .i_rd_addr     (i_rd_addr),
    .o_rd_state    (o_rd_state),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_spike_valid (o_spike_valid),
    .o_spike_id    (o_spike_id),
    .o_spike_vec   (o_spike_vec),
    .o_overrun     (o_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] a, input logic [7:0] exp);
    i_rd_addr = a;
    #1;
    chk(tag, {24'd0, o_rd_state}, {24'd0, exp});
  endtask

  task automatic wr_cur(input logic [1:0] a, input logic [7:0] d);
    i_cur_wr_en   = 1'b1;
    i_cur_wr_addr = a;
    i_cur_wr_data = d;
    step();
    i_cur_wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Tick, then wait (bounded) for done; returns edges after the tick edge and
  // the mask of spike_valid pulses seen, including the one concurrent with done.
  task automatic run_sweep(output int edges, output logic [3:0] spk);
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
    edges  = 0;
    spk    = 4'b0000;
    while (!o_done && edges < 10) begin
      step();
      edges++;
      if (o_spike_valid) spk[o_spike_id] = 1'b1;
    end
  endtask

  initial begin : main
    int         e;
    int         ndone;
    int         nspk;
    logic [3:0] spk;

    rst_n         = 1'b0;
    i_tick        = 1'b0;
    i_cur_wr_en   = 1'b0;
    i_cur_wr_addr = 2'd0;
    i_cur_wr_data = 8'd0;
    i_thr_wr_en   = 1'b0;
    i_thr_wr_data = 8'd0;
    i_rd_addr     = 2'd0;

    // 1. Reset state
    do_reset();
    for (int i = 0; i < 4; i++) chk($sformatf("rst_state%0d", i), {24'd0, o_rd_state}, 32'd0);
    for (int i = 0; i < 4; i++) chk_state($sformatf("rst_state_rd%0d", i), 2'(i), 8'd0);
    chk("rst_busy",      {31'd0, o_busy},        32'd0);
    chk("rst_done",      {31'd0, o_done},        32'd0);
    chk("rst_spike_vec", {28'd0, o_spike_vec},   32'd0);
    chk("rst_overrun",   {31'd0, o_overrun},     32'd0);
    chk("rst_spike_v",   {31'd0, o_spike_valid}, 32'd0);

    // 2. Currents 10..40, two sweeps; second tick lands in the done cycle
    wr_cur(2'd0, 8'd10);
    wr_cur(2'd1, 8'd20);
    wr_cur(2'd2, 8'd30);
    wr_cur(2'd3, 8'd40);
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
    chk("t2_busy_after_tick", {31'd0, o_busy}, 32'd1);
    e = 0;
    while (!o_done && e < 10) begin
      step();
      e++;
    end
    chk("t2_done_latency", e, 32'd4);
    chk("t2_busy_in_done", {31'd0, o_busy}, 32'd0);
    chk_state("t2_s0", 2'd0, 8'd10);
    chk_state("t2_s1", 2'd1, 8'd20);
    chk_state("t2_s2", 2'd2, 8'd30);
    chk_state("t2_s3", 2'd3, 8'd40);
    run_sweep(e, spk);
    chk("t2_done_cycle_tick", e, 32'd4);
    chk_state("t2_s0_b", 2'd0, 8'd18);
    chk_state("t2_s3_b", 2'd3, 8'd75);
    chk("t2_no_spikes", {28'd0, spk}, 32'd0);

    // 3. Threshold boundary: s == thr fires
    do_reset();
    wr_cur(2'd2, 8'd230);
    run_sweep(e, spk);
    chk_state("t3_s2", 2'd2, 8'd230);
    chk("t3_spk_a", {28'd0, spk}, 32'd0);
    chk("t3_vec_a", {28'd0, o_spike_vec}, 32'd0);
    run_sweep(e, spk);
    chk("t3_spk_b", {28'd0, spk}, 32'h4);
    chk("t3_vec_b", {28'd0, o_spike_vec}, 32'h4);
    chk_state("t3_s2_b", 2'd2, 8'd0);

    // 4. Wraparound: 255 + 100 + 50 + 25 = 430 -> 174
    do_reset();
    wr_cur(2'd0, 8'd200);
    run_sweep(e, spk);
    chk_state("t4_s0_pre", 2'd0, 8'd200);
    wr_cur(2'd0, 8'd255);
    run_sweep(e, spk);
    chk_state("t4_s0_wrap", 2'd0, 8'd174);
    chk("t4_spk", {28'd0, spk}, 32'd0);

    // 5. Overrun, same-cycle current write, mid-sweep threshold write
    do_reset();
    wr_cur(2'd1, 8'd150);
    run_sweep(e, spk);
    chk_state("t5_s1_pre", 2'd1, 8'd150);
    wr_cur(2'd1, 8'd0);
    wr_cur(2'd0, 8'd50);
    i_tick        = 1'b1;
    i_cur_wr_en   = 1'b1;
    i_cur_wr_addr = 2'd0;
    i_cur_wr_data = 8'd99;
    step();
    i_cur_wr_en   = 1'b0;
    i_thr_wr_en   = 1'b1;
    i_thr_wr_data = 8'd100;
    step();
    i_tick      = 1'b0;
    i_thr_wr_en = 1'b0;
    chk("t5_overrun_pulse", {31'd0, o_overrun}, 32'd1);
    chk("t5_busy_overrun",  {31'd0, o_busy},    32'd1);
    nspk = o_spike_valid ? 1 : 0;
    step();
    chk("t5_overrun_clear", {31'd0, o_overrun}, 32'd0);
    ndone = 0;
    if (o_spike_valid) nspk++;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_done) ndone++;
      if (o_spike_valid) nspk++;
    end
    chk("t5_one_done", ndone, 32'd1);
    chk("t5_no_spike", nspk, 32'd0);
    chk_state("t5_s0_old_cur", 2'd0, 8'd50);
    chk_state("t5_s1_old_thr", 2'd1, 8'd130);
    run_sweep(e, spk);
    chk("t5_c_latency", e, 32'd4);
    chk("t5_c_spk", {28'd0, spk}, 32'h2);
    chk("t5_c_vec", {28'd0, o_spike_vec}, 32'h2);
    chk_state("t5_c_s0", 2'd0, 8'd142);
    chk_state("t5_c_s1", 2'd1, 8'd0);

    // 6. Reset mid-sweep at idx=2
    wr_cur(2'd2, 8'd77);
    i_tick = 1'b1;
    step();
    i_tick = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("t6_busy",    {31'd0, o_busy},        32'd0);
    chk("t6_done",    {31'd0, o_done},        32'd0);
    chk("t6_spike_v", {31'd0, o_spike_valid}, 32'd0);
    for (int i = 0; i < 4; i++) chk_state($sformatf("t6_s%0d", i), 2'(i), 8'd0);
    rst_n = 1'b1;
    ndone = 0;
    nspk  = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_done) ndone++;
      if (o_spike_valid) nspk++;
    end
    chk("t6_no_done",  ndone, 32'd0);
    chk("t6_no_spike", nspk,  32'd0);
    chk("t6_idle",     {31'd0, o_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
